// File: rtl/uniform_rng_scheduler_pkg.sv
// Shared types and constants for the uniform RNG scheduler: FSM states, LFSR polynomial,
// default seed and the range loaded at reset.
package rng_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StScale,
        StDone
    } state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois form
    localparam logic [31:0] LfsrMask    = 32'h0040_0007;
    localparam logic [31:0] SeedDefault = 32'h0000_0002;

    localparam int RangeLoRst = -2;
    localparam int RangeHiRst = 2;

    function automatic logic [31:0] lfsr_step(input logic [31:0] lfsr);
        return {lfsr[30:0], 1'b0} ^ (lfsr[31] ? LfsrMask : 32'h0);
    endfunction

endpackage

// File: rtl/uniform_rng_scheduler_if.sv
// Request/grant, sample and configuration signals of the RNG scheduler. The scheduler
// is the slave; requesters and the configuration bus together act as the master.
interface uniform_rng_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic signed [DATA_W-1:0] rnd_o;
    logic                     rnd_valid_o;
    logic                     cfg_wr_i;
    logic signed [DATA_W-1:0] cfg_lo_i;
    logic signed [DATA_W-1:0] cfg_hi_i;
    logic                     cfg_err_o;
    logic                     seed_wr_i;
    logic [31:0]              seed_i;
    logic                     busy_o;

    modport slave (
        input  req_i,
        input  cfg_wr_i,
        input  cfg_lo_i,
        input  cfg_hi_i,
        input  seed_wr_i,
        input  seed_i,
        output gnt_o,
        output rnd_o,
        output rnd_valid_o,
        output cfg_err_o,
        output busy_o
    );

    modport master (
        output req_i,
        output cfg_wr_i,
        output cfg_lo_i,
        output cfg_hi_i,
        output seed_wr_i,
        output seed_i,
        input  gnt_o,
        input  rnd_o,
        input  rnd_valid_o,
        input  cfg_err_o,
        input  busy_o
    );

endinterface

// File: rtl/uniform_rng_scheduler_arb.sv
// Combinational round-robin pick: first asserted request at or above the pointer,
// wrapping back to index 0.
module rng_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_p,
    output logic [N-1:0]    o_win_oh,
    output logic [IdxW-1:0] o_win_idx,
    output logic            o_any
);

    logic [IdxW-1:0] w_j;
    logic            w_found;

    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_j = IdxW'((32'(i_p) + i) % N);
            if (!w_found && i_req[w_j]) begin
                o_win_oh[w_j] = 1'b1;
                o_win_idx     = w_j;
                w_found       = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uniform_rng_scheduler.sv
// Shared uniform RNG: round-robin arbitration over NUM_REQ requesters, one scaled LFSR
// sample per grant, with the range captured from the shadow registers at arbitration.
module uniform_rng_scheduler
    import rng_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 16,
    parameter logic [31:0] SEED_INIT = SeedDefault
) (
    input logic                    clk,
    input logic                    rst_n,
    uniform_rng_scheduler_if.slave bus
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned SpanW = DATA_W + 1;
    localparam int unsigned ProdW = 2 * DATA_W + 1;

    state_e                   r_state;
    logic [31:0]              r_lfsr;
    logic [IdxW-1:0]          r_ptr;
    logic [IdxW-1:0]          r_owner;
    logic [NUM_REQ-1:0]       r_owner_oh;
    logic signed [DATA_W-1:0] r_sh_lo;
    logic signed [DATA_W-1:0] r_sh_hi;
    logic signed [DATA_W-1:0] r_act_lo;
    logic signed [DATA_W-1:0] r_act_hi;
    logic signed [DATA_W-1:0] r_rnd;
    logic [NUM_REQ-1:0]       r_gnt;
    logic                     r_valid;
    logic                     r_cfg_err;

    logic [NUM_REQ-1:0]       w_win_oh;
    logic [IdxW-1:0]          w_win_idx;
    logic                     w_win_any;

    logic signed [SpanW-1:0]  w_lo_ext;
    logic signed [SpanW-1:0]  w_hi_ext;
    logic [SpanW-1:0]         w_span;
    logic [DATA_W-1:0]        w_r;
    logic [ProdW-1:0]         w_prod;
    logic [SpanW-1:0]         w_offset;
    logic signed [SpanW-1:0]  w_sum;
    logic signed [DATA_W-1:0] w_result;
    logic [IdxW-1:0]          w_ptr_next;

    rng_rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_arb (
        .i_req     (bus.req_i),
        .i_p       (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_win_any)
    );

    // One extra bit keeps the full-range span (2^DATA_W) and the sum from overflowing;
    // offset < span, so lo + offset never leaves [lo, hi].
    assign w_lo_ext   = {r_act_lo[DATA_W-1], r_act_lo};
    assign w_hi_ext   = {r_act_hi[DATA_W-1], r_act_hi};
    assign w_span     = $unsigned(w_hi_ext - w_lo_ext) + SpanW'(1);
    assign w_r        = r_lfsr[31 -: DATA_W];
    assign w_prod     = ProdW'(w_r) * ProdW'(w_span);
    assign w_offset   = SpanW'(w_prod >> DATA_W);
    assign w_sum      = w_lo_ext + $signed(w_offset);
    assign w_result   = DATA_W'(w_sum);

    assign w_ptr_next = (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + IdxW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_lfsr     <= SEED_INIT;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_sh_lo    <= DATA_W'(RangeLoRst);
            r_sh_hi    <= DATA_W'(RangeHiRst);
            r_act_lo   <= DATA_W'(RangeLoRst);
            r_act_hi   <= DATA_W'(RangeHiRst);
            r_rnd      <= '0;
            r_gnt      <= '0;
            r_valid    <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;

            // Shadow only; a draw in flight keeps the range it latched at arbitration
            if (bus.cfg_wr_i) begin
                if (bus.cfg_lo_i > bus.cfg_hi_i) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_sh_lo   <= bus.cfg_lo_i;
                    r_sh_hi   <= bus.cfg_hi_i;
                    r_cfg_err <= 1'b0;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.seed_wr_i) begin
                        r_lfsr <= (bus.seed_i == 32'h0) ? SEED_INIT : bus.seed_i;
                    end else if (w_win_any) begin
                        r_owner    <= w_win_idx;
                        r_owner_oh <= w_win_oh;
                        r_act_lo   <= r_sh_lo;
                        r_act_hi   <= r_sh_hi;
                        r_state    <= StStep;
                    end
                end
                StStep: begin
                    r_lfsr  <= lfsr_step(r_lfsr);
                    r_state <= StScale;
                end
                StScale: begin
                    r_rnd   <= w_result;
                    r_gnt   <= r_owner_oh;
                    r_valid <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.rnd_o       = r_rnd;
    assign bus.rnd_valid_o = r_valid;
    assign bus.cfg_err_o   = r_cfg_err;
    assign bus.busy_o      = (r_state != StIdle);

endmodule
